// File: rtl/spi_frame_sender.sv
// SPI mode-0 frame sender: shifts one 32-bit frame {p1,p2} out MSB first,
// captures the 32-bit echo from sdo and reports it in rx_word on completion.
module spi_frame_sender #(
  parameter int unsigned CLKDIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] p1,
  input  logic [15:0] p2,
  output logic        sck,
  output logic        sdi,
  input  logic        sdo,
  output logic        load,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_word
);

  localparam int unsigned HCNT_W   = 8;
  localparam int unsigned BCNT_W   = 6;
  localparam int unsigned FRAME_W  = 32;
  localparam logic [HCNT_W-1:0] HALF_RELOAD = HCNT_W'(CLKDIV - 1);
  localparam logic [BCNT_W-1:0] LAST_BIT    = BCNT_W'(FRAME_W);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEAD     = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    TRAIL    = 3'd4
  } state_t;

  state_t                state;
  logic [HCNT_W-1:0]     hcnt;
  logic [BCNT_W-1:0]     bit_cnt;
  // Bits still to transmit; the bit currently on sdi is already out of here.
  logic [FRAME_W-2:0]    tx_shift;
  logic [FRAME_W-1:0]    rx_shift;

  // Frame sequencer: phase timing, bit shifting, echo capture and handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hcnt     <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      sck      <= 1'b0;
      sdi      <= 1'b0;
      load     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_word  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sck  <= 1'b0;
          sdi  <= 1'b0;
          load <= 1'b0;
          busy <= 1'b0;
          // busy still high here means this is the done cycle: start is ignored.
          if (start && !busy) begin
            state    <= LEAD;
            hcnt     <= HALF_RELOAD;
            bit_cnt  <= '0;
            tx_shift <= {p1[14:0], p2};
            rx_shift <= '0;
            sdi      <= p1[15];
            load     <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LEAD, SHIFT_LO: begin
          if (hcnt == '0) begin
            state    <= SHIFT_HI;
            hcnt     <= HALF_RELOAD;
            sck      <= 1'b1;
            rx_shift <= {rx_shift[FRAME_W-2:0], sdo};
            bit_cnt  <= bit_cnt + BCNT_W'(1);
          end else begin
            hcnt <= hcnt - HCNT_W'(1);
          end
        end
        SHIFT_HI: begin
          if (hcnt == '0) begin
            hcnt <= HALF_RELOAD;
            sck  <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state <= TRAIL;
            end else begin
              state    <= SHIFT_LO;
              sdi      <= tx_shift[FRAME_W-2];
              tx_shift <= {tx_shift[FRAME_W-3:0], 1'b0};
            end
          end else begin
            hcnt <= hcnt - HCNT_W'(1);
          end
        end
        TRAIL: begin
          if (hcnt == '0) begin
            state   <= IDLE;
            load    <= 1'b0;
            done    <= 1'b1;
            rx_word <= rx_shift;
          end else begin
            hcnt <= hcnt - HCNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_sender.sv
// Bench for spi_frame_sender: two instances (CLKDIV=4 and CLKDIV=1) sharing
// stimulus, checked against an expected-frame model built from {p1,p2}.
module tb_spi_frame_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sel;
  logic        loop;
  logic [15:0] p1, p2;
  logic        sdo_drv;

  logic        a_sck, a_sdi, a_sdo, a_load, a_busy, a_done;
  logic        b_sck, b_sdi, b_sdo, b_load, b_busy, b_done;
  logic [31:0] a_rx, b_rx;
  logic        a_start, b_start;

  logic        m_sck, m_sdi, m_load, m_busy, m_done;
  logic [31:0] m_rx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign a_start = start & ~sel;
  assign b_start = start & sel;
  assign a_sdo   = loop ? a_sdi : sdo_drv;
  assign b_sdo   = loop ? b_sdi : sdo_drv;

  assign m_sck  = sel ? b_sck  : a_sck;
  assign m_sdi  = sel ? b_sdi  : a_sdi;
  assign m_load = sel ? b_load : a_load;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_rx   = sel ? b_rx   : a_rx;

  spi_frame_sender #(.CLKDIV(4)) u_div4 (
    .clk(clk), .reset(reset), .start(a_start), .p1(p1), .p2(p2),
    .sck(a_sck), .sdi(a_sdi), .sdo(a_sdo), .load(a_load),
    .busy(a_busy), .done(a_done), .rx_word(a_rx)
  );

  spi_frame_sender #(.CLKDIV(1)) u_div1 (
    .clk(clk), .reset(reset), .start(b_start), .p1(p1), .p2(p2),
    .sck(b_sck), .sdi(b_sdi), .sdo(b_sdo), .load(b_load),
    .busy(b_busy), .done(b_done), .rx_word(b_rx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full frame: start pulse, extra start pulses mid-frame and in the done
  // cycle, p1/p2 changed right after acceptance; expectations come from the
  // frame value and the half-period arithmetic.
  task automatic run_frame(input int cdiv, input logic [15:0] q1, input logic [15:0] q2,
                           input logic lp, input string name);
    logic [31:0] exp_tx;
    logic [31:0] echo_pat;
    logic [31:0] sent;
    logic [31:0] rx_at;
    logic        prev_sck;
    logic        prev_sdi;
    logic        busy_at_done;
    logic        busy_after;
    int          rises, bad_time, unstable, load_cnt, done_n, done_cnt, limit;
    exp_tx       = {q1, q2};
    echo_pat     = lp ? exp_tx : $urandom;
    sent         = '0;
    rx_at        = '0;
    prev_sck     = 1'b0;
    prev_sdi     = 1'b0;
    busy_at_done = 1'b0;
    busy_after   = 1'b1;
    rises = 0; bad_time = 0; unstable = 0; load_cnt = 0;
    done_n = -1; done_cnt = 0;
    limit = 70 * cdiv + 20;
    loop    = lp;
    p1      = q1;
    p2      = q2;
    sdo_drv = echo_pat[31];
    start   = 1'b1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (n == 0) begin
        start = 1'b0;
        p1 = 16'($urandom);
        p2 = 16'($urandom);
      end
      if (n == 10) start = 1'b1;
      if (n == 11) start = 1'b0;
      if (m_load) load_cnt++;
      if (m_sck && !prev_sck) begin
        rises++;
        if (rises <= 32) sent[32 - rises] = m_sdi;
        if (n != (2 * rises - 1) * cdiv) bad_time++;
        if (m_sdi !== prev_sdi) unstable++;
      end
      prev_sck = m_sck;
      prev_sdi = m_sdi;
      if (m_done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_n       = n;
          busy_at_done = m_busy;
          rx_at        = m_rx;
          start        = 1'b1;
        end
      end
      if (done_n >= 0 && n == done_n + 1) begin
        busy_after = m_busy;
        start      = 1'b0;
      end
      if (!lp && rises < 32) sdo_drv = echo_pat[31 - rises];
      if (done_n >= 0 && n == done_n + 6) break;
    end
    start = 1'b0;
    check({name, " tx_bits"},     sent,                exp_tx);
    check({name, " rise_count"},  32'(rises),          32'd32);
    check({name, " rise_timing"}, 32'(bad_time),       32'd0);
    check({name, " sdi_stable"},  32'(unstable),       32'd0);
    check({name, " load_len"},    32'(load_cnt),       32'(65 * cdiv));
    check({name, " done_time"},   32'(done_n),         32'(65 * cdiv));
    check({name, " done_count"},  32'(done_cnt),       32'd1);
    check({name, " busy_done"},   32'(busy_at_done),   32'd1);
    check({name, " busy_after"},  32'(busy_after),     32'd0);
    check({name, " rx_at_done"},  rx_at,               echo_pat);
    check({name, " rx_held"},     m_rx,                echo_pat);
    check({name, " idle_lines"},  32'({m_sck, m_sdi, m_load, m_busy}), 32'd0);
  endtask

  // Reset asserted mid-frame on the CLKDIV=4 instance at E0+100.
  task automatic abort_test();
    int done_seen;
    done_seen = 0;
    sel = 1'b0; loop = 1'b0; sdo_drv = 1'b1;
    p1 = 16'($urandom); p2 = 16'($urandom);
    start = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (a_done) done_seen++;
    end
    check("abort pre_load", 32'({a_load, a_busy}), 32'd3);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort async_lines", 32'({a_sck, a_load, a_busy, a_done, a_sdi}), 32'd0);
    check("abort rx_cleared", a_rx, 32'd0);
    repeat (3) begin
      @(negedge clk);
      if (a_done) done_seen++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_done) done_seen++;
    end
    check("abort no_done", 32'(done_seen), 32'd0);
    check("abort rx_after", a_rx, 32'd0);
    check("abort idle", 32'({a_sck, a_load, a_busy}), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sel = 1'b0; loop = 1'b0;
    p1 = '0; p2 = '0; sdo_drv = 1'b0;
    repeat (3) @(negedge clk);
    check("reset a_lines", 32'({a_sck, a_sdi, a_load, a_busy, a_done}), 32'd0);
    check("reset b_lines", 32'({b_sck, b_sdi, b_load, b_busy, b_done}), 32'd0);
    check("reset a_rx", a_rx, 32'd0);
    check("reset b_rx", b_rx, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset idle", 32'({a_load, a_busy, b_load, b_busy}), 32'd0);

    sel = 1'b0;
    run_frame(4, 16'hA5C3, 16'h0F0F, 1'b0, "div4 a5c3");
    run_frame(4, 16'h1234, 16'hBEEF, 1'b1, "div4 loop1");
    run_frame(4, 16'h0000, 16'hFFFF, 1'b1, "div4 loop2");
    abort_test();
    run_frame(4, 16'($urandom), 16'($urandom), 1'b0, "div4 after_abort");

    sel = 1'b1;
    run_frame(1, 16'hFFFF, 16'h0001, 1'b0, "div1 ffff");
    run_frame(1, 16'($urandom), 16'($urandom), 1'b1, "div1 loop");
    for (int i = 0; i < 3; i++) begin
      run_frame(1, 16'($urandom), 16'($urandom), 1'($urandom), "div1 rand");
    end
    sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      run_frame(4, 16'($urandom), 16'($urandom), 1'($urandom), "div4 rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_sender.md
SPI_FRAME_SENDER -- requirements
Module: spi_frame_sender

Interface
REQ-001 SHALL have parameter CLKDIV, default 4, meaning clk cycles per sck half-period (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to send one frame; sampled only in IDLE.
REQ-005 SHALL have port p1  input  16  first word of the frame; captured when start is accepted.
REQ-006 SHALL have port p2  input  16  second word of the frame; captured when start is accepted.
REQ-007 SHALL have port sck  output  1  SPI serial clock, mode 0 (idle low).
REQ-008 SHALL have port sdi  output  1  serial data to the receiver, MSB first.
REQ-009 SHALL have port sdo  input  1  serial echo from the receiver, sampled on sck rise.
REQ-010 SHALL have port load  output  1  frame strobe, high for the whole frame.
REQ-011 SHALL have port busy  output  1  high from start acceptance through the cycle load falls.
REQ-012 SHALL have port done  output  1  one-clk pulse marking frame completion.
REQ-013 SHALL have port rx_word  output  32  echo bits captured during the last completed frame.

Function
REQ-014 SHALL implement states IDLE, LEAD, SHIFT_HI, SHIFT_LO, TRAIL; IDLE is the reset state.
REQ-015 SHALL accept start only in IDLE, on clk edge E0; start during any other state is ignored, with no queuing.
REQ-016 At E0, SHALL load a 32-bit shift register with {p1,p2}, set load=1, busy=1, sck=0, sdi=p1[15], and enter LEAD.
REQ-017 SHALL hold each phase for exactly CLKDIV clk cycles using a half-period counter that reloads on every phase change.
REQ-018 LEAD -> SHIFT_HI at E0+CLKDIV: sck=1, sample sdo into the shift-register LSB side.
REQ-019 SHIFT_HI -> SHIFT_LO after CLKDIV cycles: sck=0, shift left by one, sdi=next bit.
REQ-020 SHALL count 32 rising sck edges with a 6-bit bit counter; the k-th rise (k=1..32) occurs at E0+(2k-1)*CLKDIV.
REQ-021 After the 32nd fall at E0+64*CLKDIV, SHALL enter TRAIL with sck=0, load=1, and sdi holding its last value.
REQ-022 At E0+65*CLKDIV, SHALL leave TRAIL: load=0, done=1 for exactly one cycle, busy=0 on the following cycle, rx_word updated with the 32 captured bits, then IDLE.
REQ-023 sdi SHALL change only while sck is low (on the falling-edge phase or at E0), never in the same clk cycle sck rises.
REQ-024 rx_word SHALL hold its value between frames; bit 31 is the first bit sampled.
REQ-025 In IDLE, SHALL drive sck=0, load=0, sdi=0, done=0, busy=0.
REQ-026 If start is high in the same cycle done pulses, it SHALL be ignored; a new frame requires start in IDLE.
REQ-027 With CLKDIV=1, SHALL produce sck at clk/2 with identical edge ordering.

Reset
REQ-028 reset SHALL force, asynchronously, state=IDLE, sck=0, load=0, sdi=0, busy=0, done=0, rx_word=0, and clear all counters.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no done pulse, and SHALL leave rx_word=0.
REQ-030 After reset deasserts, SHALL accept start no earlier than the first clk edge with reset low.

Verification
REQ-031 CLKDIV=4, p1=16'hA5C3, p2=16'h0F0F, start one cycle -> sdi bits at 32 sck rises equal 32'hA5C30F0F MSB first; load high for exactly 260 clk; done pulses at E0+260.
REQ-032 Loop sdi back to sdo, p1=16'h1234, p2=16'hBEEF -> rx_word=32'h1234BEEF at done; a second frame with 16'h0000/16'hFFFF -> rx_word=32'h0000FFFF.
REQ-033 Pulse start at E0+10 and again in the done cycle -> exactly one frame, one done pulse, busy low after it.
REQ-034 Assert reset at E0+100 (CLKDIV=4) -> sck, load, busy go 0 immediately; no done; rx_word=0; next start runs a full correct frame.
REQ-035 CLKDIV=1, p1=16'hFFFF, p2=16'h0001 -> sck period 2 clk, load high 65 clk, and a checker confirms sdi stable at every sck rise.
REQ-036 Change p1/p2 mid-frame -> transmitted bits unaffected, equal to values captured at E0.
